// File: rtl/ps2_keymap_pkg.sv
// Shared constants, decoder state type and case helper for the PS/2 set-2 keymap.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_state_t;

  // Only lowercase letters have an uppercase form; digits and controls pass through.
  function automatic logic [7:0] apply_case(input logic [7:0] chr, input logic upper);
    return (upper && chr >= "a" && chr <= "z") ? chr - 8'h20 : chr;
  endfunction

endpackage

// File: rtl/ps2_keymap_if.sv
// Scancode strobe in, ASCII valid/ready stream out, bundled for the keymap port.
// Latency: wiring only.
// Backpressure: key side has none; ASCII side pops on ascii_valid && ascii_ready.
interface ps2_keymap_if;
  logic [7:0] key_value;
  logic       key_valid;
  logic [7:0] ascii_value;
  logic       ascii_valid;
  logic       ascii_ready;

  modport master (
    output key_value, key_valid, ascii_ready,
    input  ascii_value, ascii_valid
  );

  modport slave (
    input  key_value, key_valid, ascii_ready,
    output ascii_value, ascii_valid
  );
endinterface

// File: rtl/ps2_keymap_fifo.sv
// Generic 8-bit FIFO with occupancy count, sticky drop flag and a registered head.
// Latency: a push into an empty FIFO is visible at head_dat/empty after one edge.
// Backpressure: push while full is dropped and sets overflow unless a pop frees a slot the same cycle.
module ps2_keymap_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [7:0]                  push_dat,
  input  logic                        pop,
  output logic [7:0]                  head_dat,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] cnt;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign empty   = (cnt == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rd_nxt  = rd_ptr + AW'(1);
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      head_dat <= 8'h00;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_nxt;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
      // Head is a register: bypass the incoming byte when it becomes the only entry.
      if (pop_ok) begin
        head_dat <= (push_ok && cnt == CW'(1)) ? push_dat : mem[rd_nxt];
      end else if (push_ok && empty) begin
        head_dat <= push_dat;
      end
    end
  end
endmodule

// File: rtl/ps2_keymap.sv
// PS/2 set-2 make codes to ASCII with shift/caps case, repeat filter and output FIFO (caps lock under PS2_CAPSLOCK_EN).
// Latency: make strobe sampled at edge N shows on ascii_valid after edge N+1 when the FIFO was empty.
// Backpressure: key input never stalls; ascii_ready pops, a full FIFO drops the char and sets sticky overflow.
module ps2_keymap
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int REPEAT_SUPPRESS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  ps2_keymap_if.slave                 key_if,
  output logic                        shift_held,
  output logic                        caps_on,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  ps2_state_t state;
  logic       lshift_q;
  logic       rshift_q;
  logic [7:0] held_key;
  logic       push_vld;
  logic [7:0] push_dat;
  logic [7:0] map_chr;
  logic       map_hit;
  logic       repeat_hit;
  logic       fifo_empty;
  logic [7:0] key;

  assign key        = key_if.key_value;
  assign shift_held = lshift_q | rshift_q;
  assign repeat_hit = (REPEAT_SUPPRESS != 0) && (key == held_key);

`ifdef PS2_CAPSLOCK_EN
  logic caps_q;
  assign caps_on = caps_q;
`else
  assign caps_on = 1'b0;
`endif

  always_comb begin
    map_chr = 8'h00;
    case (key)
      8'h1C: map_chr = "a";  8'h32: map_chr = "b";  8'h21: map_chr = "c";  8'h23: map_chr = "d";
      8'h24: map_chr = "e";  8'h2B: map_chr = "f";  8'h34: map_chr = "g";  8'h33: map_chr = "h";
      8'h43: map_chr = "i";  8'h3B: map_chr = "j";  8'h42: map_chr = "k";  8'h4B: map_chr = "l";
      8'h3A: map_chr = "m";  8'h31: map_chr = "n";  8'h44: map_chr = "o";  8'h4D: map_chr = "p";
      8'h15: map_chr = "q";  8'h2D: map_chr = "r";  8'h1B: map_chr = "s";  8'h2C: map_chr = "t";
      8'h3C: map_chr = "u";  8'h2A: map_chr = "v";  8'h1D: map_chr = "w";  8'h22: map_chr = "x";
      8'h35: map_chr = "y";  8'h1A: map_chr = "z";
      8'h45: map_chr = "0";  8'h16: map_chr = "1";  8'h1E: map_chr = "2";  8'h26: map_chr = "3";
      8'h25: map_chr = "4";  8'h2E: map_chr = "5";  8'h36: map_chr = "6";  8'h3D: map_chr = "7";
      8'h3E: map_chr = "8";  8'h46: map_chr = "9";
      8'h29: map_chr = 8'h20;
      8'h5A: map_chr = 8'h0D;
      8'h66: map_chr = 8'h08;
      default: map_chr = 8'h00;
    endcase
    // Every mapped character is non-zero, so zero doubles as "unmapped".
    map_hit = (map_chr != 8'h00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      held_key <= 8'h00;
      push_vld <= 1'b0;
      push_dat <= 8'h00;
`ifdef PS2_CAPSLOCK_EN
      caps_q   <= 1'b0;
`endif
    end else begin
      push_vld <= 1'b0;
      if (key_if.key_valid) begin
        case (state)
          IDLE: begin
            if (key == PS2_EXT) begin
              state <= EXT;
            end else if (key == PS2_BRK) begin
              state <= BRK;
            end else if (key == PS2_LSHIFT) begin
              lshift_q <= 1'b1;
            end else if (key == PS2_RSHIFT) begin
              rshift_q <= 1'b1;
`ifdef PS2_CAPSLOCK_EN
            end else if (key == PS2_CAPS) begin
              if (!repeat_hit) caps_q <= ~caps_q;
              held_key <= key;
`endif
            end else if (map_hit && !repeat_hit) begin
              held_key <= key;
              push_vld <= 1'b1;
              push_dat <= apply_case(map_chr, shift_held ^ caps_on);
            end
          end
          EXT:     state <= (key == PS2_BRK) ? EXT_BRK : IDLE;
          BRK: begin
            if (key == PS2_LSHIFT) lshift_q <= 1'b0;
            if (key == PS2_RSHIFT) rshift_q <= 1'b0;
            if (key == held_key)   held_key <= 8'h00;
            state <= IDLE;
          end
          EXT_BRK: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  ps2_keymap_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_vld),
    .push_dat (push_dat),
    .pop      (key_if.ascii_ready),
    .head_dat (key_if.ascii_value),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (overflow)
  );

  assign key_if.ascii_valid = !fifo_empty;
endmodule

// File: tb/tb_ps2_keymap.sv
// Bench for ps2_keymap: two instances (repeat filter on / off, depths 8 / 4) share one key stream
// and are checked against a queue-based keyboard model.
module tb_ps2_keymap;
  localparam int D0 = 8;
  localparam int D1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_keymap_if if0 ();
  ps2_keymap_if if1 ();
  logic       sh0, sh1, cp0, cp1, ov0, ov1;
  logic [3:0] cnt0;
  logic [2:0] cnt1;

  ps2_keymap #(.FIFO_DEPTH(D0), .REPEAT_SUPPRESS(1)) dut (
    .clk(clk), .rst(rst), .key_if(if0), .shift_held(sh0), .caps_on(cp0),
    .fifo_count(cnt0), .overflow(ov0));
  ps2_keymap #(.FIFO_DEPTH(D1), .REPEAT_SUPPRESS(0)) dut_nr (
    .clk(clk), .rst(rst), .key_if(if1), .shift_held(sh1), .caps_on(cp1),
    .fifo_count(cnt1), .overflow(ov1));

  int total = 0;
  int bad   = 0;

  logic [7:0] amap [256];
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pool [16] = '{8'h1C, 8'h32, 8'h21, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66,
                            8'h12, 8'h59, 8'hE0, 8'hF0, 8'h75, 8'h58, 8'h24, 8'h33};

  // Keyboard model: pending prefix flags, per-instance key state, expected FIFO contents.
  logic       m_e0, m_f0;
  logic       m_l [2], m_r [2], m_caps [2], m_ovf [2];
  logic [7:0] m_held [2];
  logic [7:0] mq0 [$];
  logic [7:0] mq1 [$];

  logic       pv [2], ev [2];
  logic [7:0] pa [2], ea [2];

  function automatic logic [6:0] obs_stat(int d);
    if (d == 0) return {cnt0, ov0, sh0, cp0};
    return {1'b0, cnt1, ov1, sh1, cp1};
  endfunction

  function automatic logic [6:0] exp_stat(int d);
    int n;
    n = (d == 0) ? mq0.size() : mq1.size();
    return {4'(n), m_ovf[d], m_l[d] | m_r[d], m_caps[d]};
  endfunction

  function automatic logic [15:0] obs_out(int d);
    if (d == 0) return {if0.ascii_valid, if0.ascii_value, obs_stat(0)};
    return {if1.ascii_valid, if1.ascii_value, obs_stat(1)};
  endfunction

  task automatic model_clear();
    m_e0 = 1'b0;
    m_f0 = 1'b0;
    mq0.delete();
    mq1.delete();
    for (int d = 0; d < 2; d++) begin
      m_l[d] = 1'b0; m_r[d] = 1'b0; m_caps[d] = 1'b0; m_ovf[d] = 1'b0; m_held[d] = 8'h00;
    end
  endtask

  task automatic model_push(input int d, input logic [7:0] c);
    if (d == 0) begin
      if (mq0.size() < D0) mq0.push_back(c); else m_ovf[0] = 1'b1;
    end else begin
      if (mq1.size() < D1) mq1.push_back(c); else m_ovf[1] = 1'b1;
    end
  endtask

  task automatic model_make(input int d, input logic [7:0] b);
    logic       suppress;
    logic [7:0] c;
    suppress = (d == 0) && (m_held[d] == b);
    if (b == 8'h12) m_l[d] = 1'b1;
    else if (b == 8'h59) m_r[d] = 1'b1;
`ifdef PS2_CAPSLOCK_EN
    else if (b == 8'h58) begin
      if (!suppress) m_caps[d] = ~m_caps[d];
      m_held[d] = b;
    end
`endif
    else if (amap[b] != 8'h00 && !suppress) begin
      c = amap[b];
      if (c >= 8'h61 && c <= 8'h7A && ((m_l[d] | m_r[d]) ^ m_caps[d])) c = c - 8'h20;
      m_held[d] = b;
      model_push(d, c);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_e0 && !m_f0) begin
      if (b == 8'hE0) m_e0 = 1'b1;
      else if (b == 8'hF0) m_f0 = 1'b1;
      else for (int d = 0; d < 2; d++) model_make(d, b);
    end else if (m_e0 && !m_f0) begin
      if (b == 8'hF0) m_f0 = 1'b1; else m_e0 = 1'b0;
    end else if (!m_e0) begin
      for (int d = 0; d < 2; d++) begin
        if (b == 8'h12) m_l[d] = 1'b0;
        if (b == 8'h59) m_r[d] = 1'b0;
        if (m_held[d] == b) m_held[d] = 8'h00;
      end
      m_f0 = 1'b0;
    end else begin
      m_e0 = 1'b0;
      m_f0 = 1'b0;
    end
  endtask

  task automatic drive_key(input logic [7:0] b, input logic v);
    if0.key_value = b; if1.key_value = b;
    if0.key_valid = v; if1.key_valid = v;
  endtask

  task automatic set_ready(input logic r);
    if0.ascii_ready = r; if1.ascii_ready = r;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1; drive_key(b, 1'b1);
    @(posedge clk); #1; drive_key(8'h00, 1'b0);
    model_byte(b);
  endtask

  task automatic send_bytes(input logic [63:0] bytes, input int n);
    for (int i = 0; i < n; i++) send(bytes[8*(n-1-i) +: 8]);
  endtask

  task automatic do_reset();
    drive_key(8'h00, 1'b0);
    set_ready(1'b0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    model_clear();
  endtask

  task automatic pop_one();
    pv[0] = if0.ascii_valid; pa[0] = if0.ascii_value;
    pv[1] = if1.ascii_valid; pa[1] = if1.ascii_value;
    ev[0] = (mq0.size() > 0); ea[0] = 8'h00;
    ev[1] = (mq1.size() > 0); ea[1] = 8'h00;
    if (ev[0]) ea[0] = mq0.pop_front();
    if (ev[1]) ea[1] = mq1.pop_front();
    set_ready(1'b1);
    @(posedge clk); #1;
    set_ready(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_out(d) !== 16'h0000) begin
        bad++; $display("FAIL reset_state dut%0d: got %h want 0000", d, obs_out(d));
      end
    end
    rst = 1'b0;
    model_clear();
    send_bytes({8'h1C, 8'h12}, 2);
    idle(1);
    rst = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_out(d) !== 16'h0000) begin
        bad++; $display("FAIL async_reset dut%0d: got %h want 0000", d, obs_out(d));
      end
    end
    @(posedge clk); #1; rst = 1'b0;
    model_clear();
  endtask

  task automatic test_latency();
    do_reset();
    send(8'h1C);
    total++;
    if (if0.ascii_valid !== 1'b0) begin
      bad++; $display("FAIL latency_edge_n: got valid=%b want 0", if0.ascii_valid);
    end
    @(posedge clk); #1;
    total++;
    if ({if0.ascii_valid, if0.ascii_value} !== {1'b1, 8'h61}) begin
      bad++; $display("FAIL latency_edge_n1: got valid=%b char=%h want 1/61", if0.ascii_valid, if0.ascii_value);
    end
    send_bytes({8'hF0, 8'h1C}, 2);
    idle(1);
    repeat (2) begin
      pop_one();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (pv[d] !== ev[d] || (ev[d] && pa[d] !== ea[d])) begin
          bad++; $display("FAIL basic_pop dut%0d: got valid=%b char=%h want valid=%b char=%h", d, pv[d], pa[d], ev[d], ea[d]);
        end
      end
    end
  endtask

  task automatic test_shift();
    do_reset();
    send_bytes({8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C}, 7);
    idle(1);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_stat(d) !== exp_stat(d)) begin
        bad++; $display("FAIL shift_stat dut%0d: got %b want %b", d, obs_stat(d), exp_stat(d));
      end
    end
    repeat (3) begin
      pop_one();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (pv[d] !== ev[d] || (ev[d] && pa[d] !== ea[d])) begin
          bad++; $display("FAIL shift_pop dut%0d: got valid=%b char=%h want valid=%b char=%h", d, pv[d], pa[d], ev[d], ea[d]);
        end
      end
    end
  endtask

  task automatic test_repeat();
    do_reset();
    send_bytes({8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C}, 5);
    idle(1);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_stat(d) !== exp_stat(d)) begin
        bad++; $display("FAIL repeat_stat dut%0d: got %b want %b", d, obs_stat(d), exp_stat(d));
      end
    end
    repeat (4) begin
      pop_one();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (pv[d] !== ev[d] || (ev[d] && pa[d] !== ea[d])) begin
          bad++; $display("FAIL repeat_pop dut%0d: got valid=%b char=%h want valid=%b char=%h", d, pv[d], pa[d], ev[d], ea[d]);
        end
      end
    end
  endtask

  task automatic test_ext();
    do_reset();
    send_bytes({8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h5A, 8'h75}, 8);
    send_bytes({8'h58, 8'hF0, 8'h58}, 3);
    idle(1);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_stat(d) !== exp_stat(d)) begin
        bad++; $display("FAIL ext_stat dut%0d: got %b want %b", d, obs_stat(d), exp_stat(d));
      end
    end
    send(8'h1C);
    idle(1);
    repeat (2) begin
      pop_one();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (pv[d] !== ev[d] || (ev[d] && pa[d] !== ea[d])) begin
          bad++; $display("FAIL ext_pop dut%0d: got valid=%b char=%h want valid=%b char=%h", d, pv[d], pa[d], ev[d], ea[d]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) send(letter_codes[i]);
    idle(1);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_stat(d) !== exp_stat(d)) begin
        bad++; $display("FAIL overflow_stat dut%0d: got %b want %b", d, obs_stat(d), exp_stat(d));
      end
    end
    repeat (9) begin
      pop_one();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (pv[d] !== ev[d] || (ev[d] && pa[d] !== ea[d])) begin
          bad++; $display("FAIL overflow_pop dut%0d: got valid=%b char=%h want valid=%b char=%h", d, pv[d], pa[d], ev[d], ea[d]);
        end
      end
    end
  endtask

  // Key strobe at edge N, pop during edge N+1 so the FIFO sees push and pop together.
  task automatic push_pop_same(input logic [7:0] b);
    @(posedge clk); #1; drive_key(b, 1'b1);
    @(posedge clk); #1; drive_key(8'h00, 1'b0);
    pop_one();
    model_byte(b);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (pv[d] !== ev[d] || (ev[d] && pa[d] !== ea[d])) begin
        bad++; $display("FAIL b2b_pop dut%0d: got valid=%b char=%h want valid=%b char=%h", d, pv[d], pa[d], ev[d], ea[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    send(8'h1C);
    idle(1);
    push_pop_same(8'h32);
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({obs_stat(d), (d == 0) ? if0.ascii_value : if1.ascii_value} !== {exp_stat(d), 8'h62}) begin
        bad++; $display("FAIL b2b_single dut%0d: got %b/%h want %b/62", d, obs_stat(d),
                        (d == 0) ? if0.ascii_value : if1.ascii_value, exp_stat(d));
      end
    end
    do_reset();
    for (int i = 0; i < 8; i++) send(letter_codes[i]);
    idle(1);
    push_pop_same(letter_codes[8]);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_stat(d) !== exp_stat(d)) begin
        bad++; $display("FAIL b2b_full_stat dut%0d: got %b want %b", d, obs_stat(d), exp_stat(d));
      end
    end
    repeat (9) begin
      pop_one();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (pv[d] !== ev[d] || (ev[d] && pa[d] !== ea[d])) begin
          bad++; $display("FAIL b2b_drain dut%0d: got valid=%b char=%h want valid=%b char=%h", d, pv[d], pa[d], ev[d], ea[d]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_bytes({8'h12, 8'hF0}, 2);
    do_reset();
    send(8'h1C);
    idle(1);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_stat(d) !== exp_stat(d)) begin
        bad++; $display("FAIL reset_mid_stat dut%0d: got %b want %b", d, obs_stat(d), exp_stat(d));
      end
    end
    repeat (2) begin
      pop_one();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (pv[d] !== ev[d] || (ev[d] && pa[d] !== ea[d])) begin
          bad++; $display("FAIL reset_mid_pop dut%0d: got valid=%b char=%h want valid=%b char=%h", d, pv[d], pa[d], ev[d], ea[d]);
        end
      end
    end
  endtask

`ifdef PS2_CAPSLOCK_EN
  task automatic test_caps();
    do_reset();
    send_bytes({8'h58, 8'hF0, 8'h58, 8'h1C}, 4);
    send_bytes({8'hF0, 8'h1C, 8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12}, 8);
    send_bytes({8'h58, 8'h58, 8'hF0, 8'h58, 8'h12, 8'h1C}, 6);
    idle(1);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs_stat(d) !== exp_stat(d)) begin
        bad++; $display("FAIL caps_stat dut%0d: got %b want %b", d, obs_stat(d), exp_stat(d));
      end
    end
    repeat (4) begin
      pop_one();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (pv[d] !== ev[d] || (ev[d] && pa[d] !== ea[d])) begin
          bad++; $display("FAIL caps_pop dut%0d: got valid=%b char=%h want valid=%b char=%h", d, pv[d], pa[d], ev[d], ea[d]);
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] last;
    do_reset();
    last = 8'h1C;
    repeat (400) begin
      b = ($urandom_range(0, 5) == 0) ? last : pool[$urandom_range(0, 15)];
      last = b;
      send(b);
      idle(1);
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs_stat(d) !== exp_stat(d)) begin
          bad++; $display("FAIL random_stat dut%0d byte=%h: got %b want %b", d, b, obs_stat(d), exp_stat(d));
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        pop_one();
        for (int d = 0; d < 2; d++) begin
          total++;
          if (pv[d] !== ev[d] || (ev[d] && pa[d] !== ea[d])) begin
            bad++; $display("FAIL random_pop dut%0d: got valid=%b char=%h want valid=%b char=%h", d, pv[d], pa[d], ev[d], ea[d]);
          end
        end
      end
    end
    repeat (9) begin
      pop_one();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (pv[d] !== ev[d] || (ev[d] && pa[d] !== ea[d])) begin
          bad++; $display("FAIL random_drain dut%0d: got valid=%b char=%h want valid=%b char=%h", d, pv[d], pa[d], ev[d], ea[d]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) amap[i] = 8'h00;
    for (int i = 0; i < 26; i++) amap[letter_codes[i]] = 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) amap[digit_codes[i]] = 8'h30 + 8'(i);
    amap[8'h29] = 8'h20;
    amap[8'h5A] = 8'h0D;
    amap[8'h66] = 8'h08;
    drive_key(8'h00, 1'b0);
    set_ready(1'b0);
    model_clear();

    test_reset();
    test_latency();
    test_shift();
    test_repeat();
    test_ext();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
`ifdef PS2_CAPSLOCK_EN
    test_caps();
`endif
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_keymap.md
PS2_KEYMAP -- requirements
Module: ps2_keymap

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, output FIFO entries; power of two, 2..64.
REQ-002 Parameter REPEAT_SUPPRESS, default 1, 1 = drop typematic repeats of the held key.
REQ-003 clk  input  1  system clock, all logic rising-edge.
REQ-004 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 key_value  input  8  PS/2 set-2 scancode byte from the receiver.
REQ-006 key_valid  input  1  one-cycle strobe qualifying key_value.
REQ-007 ascii_value  output  8  ASCII at FIFO head.
REQ-008 ascii_valid  output  1  FIFO non-empty.
REQ-009 ascii_ready  input  1  consumer pop; a pop occurs when ascii_valid && ascii_ready.
REQ-010 shift_held  output  1  either shift key (0x12, 0x59) currently held.
REQ-011 caps_on  output  1  caps-lock toggle state (0 when PS2_CAPSLOCK_EN is undefined).
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-013 overflow  output  1  sticky: a character was dropped because the FIFO was full.

Function
REQ-014 Decoder FSM states IDLE, EXT, BRK, EXT_BRK; advances only on key_valid.
REQ-015 IDLE: 0xE0 -> EXT; 0xF0 -> BRK; any other byte is a make code, processed, stay IDLE.
REQ-016 EXT: 0xF0 -> EXT_BRK; other byte is an extended make, ignored (no output), -> IDLE.
REQ-017 BRK: byte is a break code; clears the shift_held bit of 0x12/0x59, clears held key if equal; -> IDLE.
REQ-018 EXT_BRK: byte discarded, -> IDLE.
REQ-019 Make of 0x12/0x59 sets its shift bit; left and right tracked separately, shift_held = OR.
REQ-020 Map: letters 0x1C a,0x32 b,0x21 c,0x23 d,0x24 e,0x2B f,0x34 g,0x33 h,0x43 i,0x3B j,0x42 k,0x4B l,0x3A m,0x31 n,0x44 o,0x4D p,0x15 q,0x2D r,0x1B s,0x2C t,0x3C u,0x2A v,0x1D w,0x22 x,0x35 y,0x1A z.
REQ-021 Map: digits 0x45 '0',0x16 '1',0x1E '2',0x26 '3',0x25 '4',0x2E '5',0x36 '6',0x3D '7',0x3E '8',0x46 '9'; 0x29 0x20; 0x5A 0x0D; 0x66 0x08.
REQ-022 Letters uppercase (subtract 0x20) when shift_held XOR caps_on; digits and controls unaffected by case.
REQ-023 Unmapped make codes produce no FIFO write.
REQ-024 Held key register records last mapped make code; REPEAT_SUPPRESS=1 drops a make equal to it until its break.
REQ-025 Latency: mapped make strobe at edge N -> ascii_valid high after edge N+1 when FIFO was empty.
REQ-026 Push when full without simultaneous pop: character dropped, overflow set, contents unchanged.
REQ-027 Push and pop in same cycle: both occur, including when full; fifo_count unchanged.
REQ-028 Pointers wrap modulo FIFO_DEPTH; ascii_value is don't-care when empty but registered.

Reset
REQ-029 rst asserted: FSM IDLE, FIFO empty, fifo_count 0, ascii_valid 0, ascii_value 0x00, shift bits 0, caps_on 0, held key 0x00, overflow 0.
REQ-030 rst mid-sequence (e.g. after 0xF0) abandons the sequence; next byte decoded from IDLE.

Configuration
REQ-031 Macro PS2_CAPSLOCK_EN defined: make of 0x58 toggles caps_on (suppressed repeat does not re-toggle); 0x58 produces no character.
REQ-032 PS2_CAPSLOCK_EN undefined: caps_on tied 0, 0x58 treated as unmapped.

Structure
REQ-033 Package ps2_pkg holds constants PS2_EXT (0xE0), PS2_BRK (0xF0), PS2_LSHIFT, PS2_RSHIFT, PS2_CAPS, and the FSM state typedef.
REQ-034 Sub-module ps2_keymap_fifo (parametrised FIFO_DEPTH, 8-bit) holds storage and count; the scancode table stays combinational inside ps2_keymap.

Verification
REQ-035 Bytes 0x1C, 0xF0, 0x1C -> one entry 0x61; ascii_valid 0 after pop.
REQ-036 0x12, 0x1C, 0xF0, 0x1C, 0xF0, 0x12, 0x1C -> entries 0x41 then 0x61; shift_held 0 at end.
REQ-037 0x1C x3 then 0xF0 0x1C, REPEAT_SUPPRESS=1 -> single 0x61; REPEAT_SUPPRESS=0 -> three 0x61.
REQ-038 0xE0 0x75, 0xE0 0xF0 0x75 -> no entries, FSM back in IDLE.
REQ-039 FIFO_DEPTH=8, ascii_ready=0, nine mapped makes -> fifo_count 8, overflow 1, pops yield first eight in order.
REQ-040 PS2_CAPSLOCK_EN: 0x58, 0xF0, 0x58, 0x1C -> caps_on 1, entry 0x41; with 0x12 held -> 0x61.
